// File: rtl/pc_unit.sv
// Program counter with BOOT/RUN/HALTED sequencing.
// Redirect priority is jr > jump > branch > sequential, and the PC updates one edge after the controls are sampled.
module pc_unit #(
  parameter logic [29:0] RESET_PC = 30'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch,
  input  logic [15:0] branch_imm,
  input  logic        jump,
  input  logic [25:0] jump_target,
  input  logic        jr,
  input  logic [29:0] jr_addr,
  input  logic        halt,
  output logic [29:0] pc,
  output logic [29:0] pc_plus1,
  output logic        fetch_valid,
  output logic        halted
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [29:0] r_pc;
  logic [29:0] w_nextPc;
  logic [29:0] w_pcPlus1;
  logic [29:0] w_branchPc;
  logic [29:0] w_jumpPc;
  logic [29:0] w_redirectPc;

  assign w_pcPlus1  = r_pc + 30'd1;
  assign w_branchPc = w_pcPlus1 + {{14{branch_imm[15]}}, branch_imm};
  assign w_jumpPc   = {w_pcPlus1[29:26], jump_target};

  always_comb begin
    w_redirectPc = w_pcPlus1;
    if (jr)
      w_redirectPc = jr_addr;
    else if (jump)
      w_redirectPc = w_jumpPc;
    else if (branch)
      w_redirectPc = w_branchPc;
  end

  // Stall freezes everything in RUN, including halt; halt beats any redirect.
  always_comb begin
    w_nextState = r_state;
    w_nextPc    = r_pc;
    case (r_state)
      BOOT: w_nextState = RUN;
      RUN: begin
        if (!stall) begin
          if (halt)
            w_nextState = HALTED;
          else
            w_nextPc = w_redirectPc;
        end
      end
      HALTED: w_nextState = HALTED;
      default: w_nextState = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= BOOT;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_nextState;
      r_pc    <= w_nextPc;
    end
  end

  assign pc          = r_pc;
  assign pc_plus1    = w_pcPlus1;
  assign fetch_valid = (r_state == RUN);
  assign halted      = (r_state == HALTED);

endmodule

// File: tb/tb_pc_unit.sv
// Vector-table bench for pc_unit: expectations are queued as each vector is driven and popped after the edge.
// A second instance with RESET_PC=30'h100 shares all inputs and is checked around the late reset.
module tb_pc_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch;
  logic [15:0] branch_imm;
  logic        jump;
  logic [25:0] jump_target;
  logic        jr;
  logic [29:0] jr_addr;
  logic        halt;
  logic [29:0] pc0, pcPlus0, pc1, pcPlus1;
  logic        fv0, halted0, fv1, halted1;

  int compared   = 0;
  int mismatched = 0;

  pc_unit dut0 (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch),
    .branch_imm(branch_imm), .jump(jump), .jump_target(jump_target),
    .jr(jr), .jr_addr(jr_addr), .halt(halt),
    .pc(pc0), .pc_plus1(pcPlus0), .fetch_valid(fv0), .halted(halted0)
  );

  pc_unit #(.RESET_PC(30'h100)) dut1 (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch),
    .branch_imm(branch_imm), .jump(jump), .jump_target(jump_target),
    .jr(jr), .jr_addr(jr_addr), .halt(halt),
    .pc(pc1), .pc_plus1(pcPlus1), .fetch_valid(fv1), .halted(halted1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stl, br;
    logic [15:0] imm;
    logic        jmp;
    logic [25:0] jt;
    logic        jrq;
    logic [29:0] jra;
    logic        hlt;
    logic [29:0] ePc;
    logic        eFv, eH;
    logic        chk1;
    logic [29:0] e1Pc;
    logic        e1Fv;
  } vec_t;

  typedef struct {
    int          idx;
    logic [29:0] ePc, ePlus;
    logic        eFv, eH;
    logic        chk1;
    logic [29:0] e1Pc;
    logic        e1Fv;
  } exp_t;

  vec_t vectors[$];
  exp_t expQ[$];

  function automatic vec_t mk(input logic rst, stl, br, input logic [15:0] imm,
                              input logic jmp, input logic [25:0] jt,
                              input logic jrq, input logic [29:0] jra, input logic hlt,
                              input logic [29:0] ePc, input logic eFv, eH,
                              input logic chk1 = 1'b0, input logic [29:0] e1Pc = '0,
                              input logic e1Fv = 1'b0);
    vec_t v;
    v.rst = rst; v.stl = stl; v.br = br; v.imm = imm; v.jmp = jmp; v.jt = jt;
    v.jrq = jrq; v.jra = jra; v.hlt = hlt; v.ePc = ePc; v.eFv = eFv; v.eH = eH;
    v.chk1 = chk1; v.e1Pc = e1Pc; v.e1Fv = e1Fv;
    return v;
  endfunction

  task automatic cmp(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s vec%0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    exp_t e;
    reset = v.rst; stall = v.stl; branch = v.br; branch_imm = v.imm;
    jump = v.jmp; jump_target = v.jt; jr = v.jrq; jr_addr = v.jra; halt = v.hlt;
    e.idx = idx; e.ePc = v.ePc; e.ePlus = v.ePc + 30'd1; e.eFv = v.eFv; e.eH = v.eH;
    e.chk1 = v.chk1; e.e1Pc = v.e1Pc; e.e1Fv = v.e1Fv;
    expQ.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (expQ.size() == 0) begin
      cmp("scoreboard_empty", -1, 32'd0, 32'd1);
      return;
    end
    e = expQ.pop_front();
    cmp("pc", e.idx, {2'b0, pc0}, {2'b0, e.ePc});
    cmp("pc_plus1", e.idx, {2'b0, pcPlus0}, {2'b0, e.ePlus});
    cmp("fetch_valid", e.idx, {31'b0, fv0}, {31'b0, e.eFv});
    cmp("halted", e.idx, {31'b0, halted0}, {31'b0, e.eH});
    if (e.chk1) begin
      cmp("pc_rst100", e.idx, {2'b0, pc1}, {2'b0, e.e1Pc});
      cmp("pc_plus1_rst100", e.idx, {2'b0, pcPlus1}, {2'b0, e.e1Pc + 30'd1});
      cmp("fetch_valid_rst100", e.idx, {31'b0, fv1}, {31'b0, e.e1Fv});
      cmp("halted_rst100", e.idx, {31'b0, halted1}, 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1; stall = 0; branch = 0; branch_imm = '0; jump = 0;
    jump_target = '0; jr = 0; jr_addr = '0; halt = 0;

    //           rst stl br  imm        jmp jt          jr  jra            hlt  ePc            fv h
    vectors.push_back(mk(1, 0, 0, 16'h0,    0, 26'h0,    0, 30'h0,          0, 30'h0,          0, 0));
    vectors.push_back(mk(0, 0, 0, 16'h0,    0, 26'h0,    0, 30'h0,          0, 30'h0,          1, 0));
    vectors.push_back(mk(0, 0, 0, 16'h0,    0, 26'h0,    0, 30'h0,          0, 30'h1,          1, 0));
    vectors.push_back(mk(0, 0, 0, 16'h0,    0, 26'h0,    0, 30'h0,          0, 30'h2,          1, 0));
    vectors.push_back(mk(0, 0, 0, 16'h0,    0, 26'h0,    0, 30'h0,          0, 30'h3,          1, 0));
    vectors.push_back(mk(0, 0, 0, 16'h0,    0, 26'h0,    1, 30'd10,         0, 30'd10,         1, 0));
    vectors.push_back(mk(0, 0, 1, 16'hFFFC, 0, 26'h0,    0, 30'h0,          0, 30'd7,          1, 0));
    vectors.push_back(mk(0, 0, 1, 16'h0005, 0, 26'h0,    0, 30'h0,          0, 30'd13,         1, 0));
    vectors.push_back(mk(0, 0, 0, 16'h0,    0, 26'h0,    1, 30'h2000_0004,  0, 30'h2000_0004,  1, 0));
    vectors.push_back(mk(0, 0, 0, 16'h0,    1, 26'h100,  0, 30'h0,          0, 30'h2000_0100,  1, 0));
    vectors.push_back(mk(0, 0, 1, 16'h5,    1, 26'h55,   1, 30'hABC,        0, 30'hABC,        1, 0));
    vectors.push_back(mk(0, 0, 1, 16'h1,    1, 26'h3,    0, 30'h0,          0, 30'h3,          1, 0));
    vectors.push_back(mk(0, 0, 0, 16'h0,    0, 26'h0,    1, 30'h3FFF_FFFF,  0, 30'h3FFF_FFFF,  1, 0));
    vectors.push_back(mk(0, 1, 0, 16'h0,    1, 26'h5,    0, 30'h0,          0, 30'h3FFF_FFFF,  1, 0));
    vectors.push_back(mk(0, 1, 0, 16'h0,    1, 26'h5,    0, 30'h0,          0, 30'h3FFF_FFFF,  1, 0));
    vectors.push_back(mk(0, 1, 1, 16'h7,    0, 26'h0,    1, 30'h123,        1, 30'h3FFF_FFFF,  1, 0));
    vectors.push_back(mk(0, 0, 0, 16'h0,    0, 26'h0,    0, 30'h0,          0, 30'h0,          1, 0));
    vectors.push_back(mk(0, 0, 1, 16'h8000, 0, 26'h0,    0, 30'h0,          0, 30'h3FFF_8001,  1, 0));
    vectors.push_back(mk(0, 0, 0, 16'h0,    0, 26'h0,    1, 30'd50,         0, 30'd50,         1, 0));
    vectors.push_back(mk(0, 0, 1, 16'h4,    0, 26'h0,    0, 30'h0,          1, 30'd50,         0, 1));
    for (int k = 0; k < 5; k++)
      vectors.push_back(mk(0, 0, 0, 16'h0,  0, 26'h0,    1, 30'h777,        0, 30'd50,         0, 1));
    vectors.push_back(mk(0, 1, 0, 16'h0,    0, 26'h0,    0, 30'h0,          1, 30'd50,         0, 1));
    // Late reset while halted, then BOOT ignoring redirects, and a reset that lands mid-stall.
    vectors.push_back(mk(1, 1, 0, 16'h0,    0, 26'h0,    1, 30'h55,         1, 30'h0,          0, 0, 1, 30'h100, 0));
    vectors.push_back(mk(0, 0, 0, 16'h0,    0, 26'h0,    1, 30'h999,        0, 30'h0,          1, 0, 1, 30'h100, 1));
    vectors.push_back(mk(0, 0, 0, 16'h0,    0, 26'h0,    0, 30'h0,          0, 30'h1,          1, 0, 1, 30'h101, 1));
    vectors.push_back(mk(1, 1, 0, 16'h0,    0, 26'h0,    0, 30'h0,          0, 30'h0,          0, 0, 1, 30'h100, 0));
    vectors.push_back(mk(0, 0, 0, 16'h0,    0, 26'h0,    0, 30'h0,          1, 30'h0,          1, 0, 1, 30'h100, 1));
    vectors.push_back(mk(0, 0, 0, 16'h0,    0, 26'h0,    0, 30'h0,          0, 30'h1,          1, 0, 1, 30'h101, 1));

    for (int i = 0; i < vectors.size(); i++) begin
      @(negedge clk);
      applyStimulus(i, vectors[i]);
      @(posedge clk);
      #1;
      checkOutput();
    end

    // Outputs must not follow inputs between edges.
    @(negedge clk);
    jr = 1'b1; jr_addr = 30'h1234; halt = 1'b1; stall = 1'b0;
    #2;
    cmp("no_comb_pc", 99, {2'b0, pc0}, 32'h1);
    cmp("no_comb_halted", 99, {31'b0, halted0}, 32'd0);

    cmp("scoreboard_drained", 100, expQ.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 The block SHALL have one parameter: RESET_PC, default 30'h0000_0000, the word address loaded into the PC on reset.
REQ-002 The block SHALL have these ports, listed as name, direction, width, meaning:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold the PC this cycle.
- branch  input  1  take PC-relative branch.
- branch_imm  input  16  signed word offset.
- jump  input  1  take absolute jump.
- jump_target  input  26  jump word-address field.
- jr  input  1  take register jump.
- jr_addr  input  30  register jump word address.
- halt  input  1  stop fetching.
- pc  output  30  current fetch word address.
- pc_plus1  output  30  pc + 1.
- fetch_valid  output  1  pc is a valid fetch address this cycle.
- halted  output  1  block is in HALTED.

Function
REQ-003 The block SHALL compute pc_plus1 combinationally as pc + 1, modulo 2^30, so 30'h3FFF_FFFF + 1 = 30'h0.
REQ-004 The block SHALL compute the branch target as pc_plus1 + sign-extend(branch_imm) to 30 bits, modulo 2^30, with no overflow flag.
REQ-005 The block SHALL compute the jump target as {pc_plus1[29:26], jump_target}.
REQ-006 The block SHALL compute the next PC in RUN with priority jr (jr_addr) > jump > branch > sequential (pc_plus1).
REQ-007 The block SHALL implement FSM states BOOT, RUN and HALTED.
REQ-008 In BOOT the block SHALL drive fetch_valid=0 and halted=0, hold pc, and go to RUN on the next edge unconditionally, ignoring all control inputs.
REQ-009 In RUN the block SHALL drive fetch_valid=1 and halted=0.
REQ-010 In RUN with stall=1, pc SHALL hold. branch, jump, jr and halt SHALL be ignored that cycle; upstream re-presents them after the stall.
REQ-011 In RUN with stall=0 and halt=1, the block SHALL go to HALTED and pc SHALL hold. halt SHALL override any simultaneous branch, jump or jr.
REQ-012 In RUN with stall=0 and halt=0, pc SHALL load the next PC from REQ-006.
REQ-013 In HALTED the block SHALL drive fetch_valid=0 and halted=1 and hold pc. Only reset SHALL exit HALTED.
REQ-014 pc, fetch_valid and halted SHALL be registered outputs or decoded from registered state only, with no combinational path from inputs.
REQ-015 A redirect SHALL take effect with one-cycle latency: inputs sampled at edge N drive pc after edge N.

Reset
REQ-016 While reset=1 at a rising edge, the block SHALL load pc=RESET_PC and state=BOOT. From that edge, fetch_valid=0, halted=0 and pc_plus1=RESET_PC+1.
REQ-017 reset SHALL override stall, halt and every redirect in every state, including mid-stall and HALTED.
REQ-018 After reset deasserts, the first fetch_valid=1 cycle SHALL present pc=RESET_PC.

Verification
REQ-019 Reset then sequential run: reset 1 cycle, no controls -> one BOOT cycle with fetch_valid=0, then pc = 0, 1, 2, 3 on successive cycles with fetch_valid=1.
REQ-020 Branch: at pc=10, branch=1, branch_imm=16'hFFFC -> next pc=7. At pc=7, branch_imm=16'h0005 -> next pc=13.
REQ-021 Jump, jr and priority:
- pc=30'h2000_0004, jump=1, jump_target=26'h000_0100 -> next pc=30'h2000_0100.
- jr=1, jump=1, branch=1, jr_addr=30'h0000_0ABC -> next pc=30'h0000_0ABC.
REQ-022 Stall and wrap:
- pc=30'h3FFF_FFFF, stall=1 for 2 cycles with jump=1 -> pc holds at 30'h3FFF_FFFF.
- Then stall=0, no controls -> pc=30'h0.
REQ-023 Halt and reset:
- pc=50, halt=1 with branch=1 -> pc stays 50, halted=1, fetch_valid=0.
- 5 further cycles with jr=1 -> unchanged.
- reset=1 with RESET_PC=30'h100 -> pc=30'h100, BOOT, then RUN.
